// File: rtl/dmem_arbiter.sv
// Two-port arbiter/sequencer in front of the 256x8 byte-addressed data memory.
// Define DMEM_ALIGN_CHECK_EN to reject misaligned requests with err0/err1 instead of truncating.
module dmem_arbiter #(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 32,
  parameter int PORT0_PRIO = 0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              ack0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef DMEM_ALIGN_CHECK_EN
  ,
  output logic              err0,
  output logic              err1
`endif
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} stateT;

  stateT             state, nextState;
  logic              rrPtr;
  logic              grantPort;
  logic              latchedWe;
  logic [ADDR_W-1:0] latchedAddr;
  logic [DATA_W-1:0] latchedWdata;
  logic [DATA_W-1:0] rdataReg;
  logic              anyReq;
  logic              pickPort;
  logic              pickWe;
  logic [ADDR_W-1:0] pickAddr;
  logic [DATA_W-1:0] pickWdata;
  logic              pickBad;
`ifdef DMEM_ALIGN_CHECK_EN
  logic              latchedErr;
`endif

  assign anyReq = req0 | req1;

  // Winner selection: a lone requester always wins; a tie goes to rrPtr unless port 0 is fixed-priority.
  always_comb begin
    pickPort = ~req0;
    if (req0 && req1) begin
      pickPort = (PORT0_PRIO != 0) ? 1'b0 : rrPtr;
    end
    pickWe    = pickPort ? we1 : we0;
    pickAddr  = pickPort ? addr1 : addr0;
    pickWdata = pickPort ? wdata1 : wdata0;
    pickBad   = 1'b0;
`ifdef DMEM_ALIGN_CHECK_EN
    pickBad   = (pickAddr[1:0] != 2'b00);
`endif
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      rrPtr        <= 1'b0;
      grantPort    <= 1'b0;
      latchedWe    <= 1'b0;
      latchedAddr  <= '0;
      latchedWdata <= '0;
      rdataReg     <= '0;
`ifdef DMEM_ALIGN_CHECK_EN
      latchedErr   <= 1'b0;
`endif
    end else begin
      state <= nextState;
      if (state == IDLE && anyReq) begin
        grantPort <= pickPort;
        rrPtr     <= ~pickPort;
        latchedWe <= pickWe;
        // A rejected request must not disturb the memory-facing address/data.
        if (!pickBad) begin
          latchedAddr  <= pickAddr & ~ADDR_W'(3);
          latchedWdata <= pickWdata;
        end
`ifdef DMEM_ALIGN_CHECK_EN
        latchedErr <= pickBad;
`endif
      end
      if (state == ACCESS && !latchedWe) begin
        rdataReg <= mem_rdata;
      end
    end
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (anyReq) nextState = pickBad ? RESP : ACCESS;
      ACCESS:  nextState = RESP;
      RESP:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Outputs decode only flops, so the memory sees clean one-cycle strobes.
  always_comb begin
    mem_read  = (state == ACCESS) && !latchedWe;
    mem_write = (state == ACCESS) && latchedWe;
    mem_addr  = latchedAddr;
    mem_wdata = latchedWdata;
    ack0      = (state == RESP) && !grantPort;
    ack1      = (state == RESP) && grantPort;
    rdata     = rdataReg;
`ifdef DMEM_ALIGN_CHECK_EN
    err0      = (state == RESP) && !grantPort && latchedErr;
    err1      = (state == RESP) && grantPort && latchedErr;
`endif
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized self-checking bench for dmem_arbiter with a transaction-level reference model.
// Also builds with DMEM_ALIGN_CHECK_EN defined.
module tb_dmem_arbiter;

`ifdef DMEM_ALIGN_CHECK_EN
  localparam bit AlignCheck = 1'b1;
`else
  localparam bit AlignCheck = 1'b0;
`endif
  localparam int MainPrio = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic        req0, we0, req1, we1;
  logic [7:0]  addr0, addr1;
  logic [31:0] wdata0, wdata1;
  logic        ack0, ack1, mem_read, mem_write;
  logic [7:0]  mem_addr;
  logic [31:0] rdata, mem_wdata, mem_rdata;

  logic        pReq0, pReq1, pAck0, pAck1, pMemRead, pMemWrite;
  logic [7:0]  pMemAddr;
  logic [31:0] pRdata, pMemWdata;
`ifdef DMEM_ALIGN_CHECK_EN
  logic        err0, err1, pErr0, pErr1;
`endif

  dmem_arbiter #(.ADDR_W(8), .DATA_W(32), .PORT0_PRIO(MainPrio)) dut (
    .clk(clk), .reset_n(reset_n),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1),
    .rdata(rdata), .mem_read(mem_read), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
`ifdef DMEM_ALIGN_CHECK_EN
    , .err0(err0), .err1(err1)
`endif
  );

  dmem_arbiter #(.ADDR_W(8), .DATA_W(32), .PORT0_PRIO(1)) dutPrio (
    .clk(clk), .reset_n(reset_n),
    .req0(pReq0), .we0(1'b0), .addr0(8'h40), .wdata0(32'h0), .ack0(pAck0),
    .req1(pReq1), .we1(1'b0), .addr1(8'h44), .wdata1(32'h0), .ack1(pAck1),
    .rdata(pRdata), .mem_read(pMemRead), .mem_write(pMemWrite),
    .mem_addr(pMemAddr), .mem_wdata(pMemWdata), .mem_rdata(32'h0)
`ifdef DMEM_ALIGN_CHECK_EN
    , .err0(pErr0), .err1(pErr1)
`endif
  );

  // Environment memory driven only by the DUT's memory port.
  logic [7:0] envMem [256];
  logic [7:0] refMem [256];
  assign mem_rdata = {envMem[mem_addr], envMem[mem_addr + 8'd1],
                      envMem[mem_addr + 8'd2], envMem[mem_addr + 8'd3]};
  always @(posedge clk) begin
    if (mem_write) begin
      envMem[mem_addr]        <= mem_wdata[31:24];
      envMem[mem_addr + 8'd1] <= mem_wdata[23:16];
      envMem[mem_addr + 8'd2] <= mem_wdata[15:8];
      envMem[mem_addr + 8'd3] <= mem_wdata[7:0];
    end
  end

  int checks = 0;
  int failures = 0;
  int writeCycles = 0;
  bit compareOn = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%08h required=0x%08h t=%0t", name, actual, expected, $time);
    end
  endtask

  // Reference model: one transaction in flight, aged 0 while on the memory bus and 1 while acking.
  bit        modActive, modWe, modErr, modRr;
  int        modAge, modPort, modWin;
  bit [7:0]  expMemAddr;
  bit [31:0] expMemWdata, expRdata;
  logic [7:0] rawAddr;

  function automatic int pickWinner(input logic r0, input logic r1, input bit rr);
    if (r0 && r1) return (MainPrio != 0) ? 0 : int'(rr);
    return r0 ? 0 : 1;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      modActive <= 1'b0; modAge <= 0; modPort <= 0; modWe <= 1'b0; modErr <= 1'b0;
      modRr <= 1'b0; expMemAddr <= '0; expMemWdata <= '0; expRdata <= '0;
    end else if (!modActive) begin
      if (req0 || req1) begin
        modWin = pickWinner(req0, req1, modRr);
        rawAddr = (modWin == 1) ? addr1 : addr0;
        modActive <= 1'b1;
        modPort   <= modWin;
        modRr     <= (modWin == 0);
        modWe     <= (modWin == 1) ? we1 : we0;
        modErr    <= AlignCheck && (rawAddr[1:0] != 2'b00);
        modAge    <= (AlignCheck && (rawAddr[1:0] != 2'b00)) ? 1 : 0;
        if (!(AlignCheck && (rawAddr[1:0] != 2'b00))) begin
          expMemAddr  <= rawAddr & 8'hFC;
          expMemWdata <= (modWin == 1) ? wdata1 : wdata0;
        end
      end
    end else if (modAge == 0) begin
      if (modWe) begin
        refMem[expMemAddr]        <= expMemWdata[31:24];
        refMem[expMemAddr + 8'd1] <= expMemWdata[23:16];
        refMem[expMemAddr + 8'd2] <= expMemWdata[15:8];
        refMem[expMemAddr + 8'd3] <= expMemWdata[7:0];
      end else begin
        expRdata <= {refMem[expMemAddr], refMem[expMemAddr + 8'd1],
                     refMem[expMemAddr + 8'd2], refMem[expMemAddr + 8'd3]};
      end
      modAge <= 1;
    end else begin
      modActive <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (mem_write) writeCycles++;
    if (compareOn) begin
      checkOutput("mem_read", 32'(mem_read), 32'(modActive && modAge == 0 && !modWe));
      checkOutput("mem_write", 32'(mem_write), 32'(modActive && modAge == 0 && modWe));
      checkOutput("mem_addr", 32'(mem_addr), 32'(expMemAddr));
      checkOutput("mem_wdata", mem_wdata, expMemWdata);
      checkOutput("ack0", 32'(ack0), 32'(modActive && modAge == 1 && modPort == 0));
      checkOutput("ack1", 32'(ack1), 32'(modActive && modAge == 1 && modPort == 1));
      checkOutput("rdata", rdata, expRdata);
`ifdef DMEM_ALIGN_CHECK_EN
      checkOutput("err0", 32'(err0), 32'(modActive && modAge == 1 && modPort == 0 && modErr));
      checkOutput("err1", 32'(err1), 32'(modActive && modAge == 1 && modPort == 1 && modErr));
`endif
    end
  end

  task automatic applyStimulus(input int port, input bit we, input logic [7:0] addr,
                               input logic [31:0] wdata, output int latency, output bit errSeen);
    @(posedge clk); #1;
    if (port == 0) begin req0 = 1'b1; we0 = we; addr0 = addr; wdata0 = wdata; end
    else begin req1 = 1'b1; we1 = we; addr1 = addr; wdata1 = wdata; end
    latency = -1;
    errSeen = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      if ((port == 0 && ack0) || (port == 1 && ack1)) begin
        latency = c;
`ifdef DMEM_ALIGN_CHECK_EN
        errSeen = (port == 0) ? err0 : err1;
`endif
        break;
      end
    end
    if (port == 0) req0 = 1'b0; else req1 = 1'b0;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_ack0"}, 32'(ack0), 32'h0);
    checkOutput({tag, "_ack1"}, 32'(ack1), 32'h0);
    checkOutput({tag, "_mem_read"}, 32'(mem_read), 32'h0);
    checkOutput({tag, "_mem_write"}, 32'(mem_write), 32'h0);
    checkOutput({tag, "_mem_addr"}, 32'(mem_addr), 32'h0);
    checkOutput({tag, "_mem_wdata"}, mem_wdata, 32'h0);
    checkOutput({tag, "_rdata"}, rdata, 32'h0);
  endtask

  task automatic randomCycle();
    if (req0) begin
      if (ack0) begin
        if ($urandom_range(1, 0) == 1) req0 = 1'b0;
        else begin
          we0 = 1'($urandom_range(1, 0));
          addr0 = ($urandom_range(3, 0) == 0) ? 8'($urandom) : 8'($urandom_range(63, 0));
          wdata0 = $urandom;
        end
      end else if ($urandom_range(3, 0) == 0) wdata0 = $urandom;
    end else if ($urandom_range(2, 0) == 0) begin
      req0 = 1'b1; we0 = 1'($urandom_range(1, 0));
      addr0 = ($urandom_range(3, 0) == 0) ? 8'($urandom) : 8'($urandom_range(63, 0));
      wdata0 = $urandom;
    end
    if (req1) begin
      if (ack1) begin
        if ($urandom_range(1, 0) == 1) req1 = 1'b0;
        else begin
          we1 = 1'($urandom_range(1, 0));
          addr1 = ($urandom_range(3, 0) == 0) ? 8'($urandom) : 8'($urandom_range(63, 0));
          wdata1 = $urandom;
        end
      end else if ($urandom_range(3, 0) == 0) wdata1 = $urandom;
    end else if ($urandom_range(2, 0) == 0) begin
      req1 = 1'b1; we1 = 1'($urandom_range(1, 0));
      addr1 = ($urandom_range(3, 0) == 0) ? 8'($urandom) : 8'($urandom_range(63, 0));
      wdata1 = $urandom;
    end
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int lat;
    bit err;
    int got[$];
    int zeros;
    logic [7:0] tmp;

    reset_n = 1'b0;
    req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0;
    req1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0;
    pReq0 = 1'b0; pReq1 = 1'b0;
    for (int i = 0; i < 256; i++) begin
      tmp = 8'($urandom);
      envMem[i] <= tmp;
      refMem[i] <= tmp;
    end
    repeat (3) @(posedge clk);
    #1;
    compareOn = 1'b1;
    checkAllZero("reset");
    @(negedge clk);
    reset_n = 1'b1;

    // Round-robin with both ports held: grants alternate starting at port 0.
    @(posedge clk); #1;
    req0 = 1'b1; we0 = 1'b0; addr0 = 8'h20;
    req1 = 1'b1; we1 = 1'b0; addr1 = 8'h24;
    for (int c = 0; c < 40 && got.size() < 4; c++) begin
      @(posedge clk); #1;
      if (ack0) got.push_back(0);
      if (ack1) got.push_back(1);
    end
    req0 = 1'b0; req1 = 1'b0;
    checkOutput("rr_grant_count", 32'(got.size()), 32'd4);
    for (int i = 0; i < 4; i++)
      if (i < got.size()) checkOutput($sformatf("rr_grant%0d", i), 32'(got[i]), 32'(i % 2));
    repeat (3) @(posedge clk);

    // Port 0 write then read of word 0x08.
    writeCycles = 0;
    applyStimulus(0, 1'b1, 8'h08, 32'hDEADBEEF, lat, err);
    checkOutput("wr08_latency", 32'(lat), 32'd2);
    checkOutput("wr08_write_cycles", 32'(writeCycles), 32'd1);
    applyStimulus(0, 1'b0, 8'h08, 32'h0, lat, err);
    checkOutput("rd08_latency", 32'(lat), 32'd2);
    checkOutput("rd08_rdata", rdata, 32'hDEADBEEF);

    // Port 1 at the top word of memory.
    applyStimulus(1, 1'b1, 8'hFC, 32'h11223344, lat, err);
    applyStimulus(1, 1'b0, 8'hFC, 32'h0, lat, err);
    checkOutput("rdFC_latency", 32'(lat), 32'd2);
    checkOutput("rdFC_rdata", rdata, 32'h11223344);
    checkOutput("rdFC_mem_addr", 32'(mem_addr), 32'h000000FC);

    // Misaligned write to 0x0A.
    writeCycles = 0;
    applyStimulus(0, 1'b1, 8'h0A, 32'h5A5A1234, lat, err);
`ifdef DMEM_ALIGN_CHECK_EN
    checkOutput("mis0A_err0", 32'(err), 32'd1);
    checkOutput("mis0A_write_cycles", 32'(writeCycles), 32'd0);
    checkOutput("mis0A_latency", 32'(lat), 32'd1);
`else
    checkOutput("mis0A_write_cycles", 32'(writeCycles), 32'd1);
    applyStimulus(0, 1'b0, 8'h08, 32'h0, lat, err);
    checkOutput("mis0A_rd08_rdata", rdata, 32'h5A5A1234);
`endif

    // Reset during the ACCESS cycle of a write must not commit it.
    applyStimulus(0, 1'b1, 8'h10, 32'hCAFEF00D, lat, err);
    @(posedge clk); #1;
    req0 = 1'b1; we0 = 1'b1; addr0 = 8'h10; wdata0 = 32'h12345678;
    @(posedge clk); #2;
    checkOutput("abort_in_access", 32'(mem_write), 32'd1);
    reset_n = 1'b0;
    #1;
    checkAllZero("abort");
    req0 = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(posedge clk);
    applyStimulus(0, 1'b0, 8'h10, 32'h0, lat, err);
    checkOutput("abort_rd10_rdata", rdata, 32'hCAFEF00D);

    // Random traffic with one reset in the middle.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(posedge clk); #1;
      randomCycle();
      if (cyc == 1500) begin
        #2;
        reset_n = 1'b0;
        #1;
        checkAllZero("midreset");
        req0 = 1'b0; req1 = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        applyStimulus(0, 1'b0, 8'h30, 32'h0, lat, err);
        checkOutput("midreset_first_grant_latency", 32'(lat), 32'd2);
      end
    end
    req0 = 1'b0; req1 = 1'b0;
    repeat (5) @(posedge clk);

    // Fixed priority: port 1 waits until port 0 drops its request.
    got.delete();
    zeros = 0;
    @(posedge clk); #1;
    pReq0 = 1'b1; pReq1 = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (pAck0) begin
        got.push_back(0);
        zeros++;
        if (zeros == 3) pReq0 = 1'b0;
      end
      if (pAck1) begin
        got.push_back(1);
        break;
      end
    end
    pReq0 = 1'b0; pReq1 = 1'b0;
    checkOutput("prio_grant_count", 32'(got.size()), 32'd4);
    for (int i = 0; i < 4; i++)
      if (i < got.size()) checkOutput($sformatf("prio_grant%0d", i), 32'(got[i]), (i == 3) ? 32'd1 : 32'd0);

    repeat (3) @(posedge clk);
    compareOn = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
